// File: rtl/lfsr_checker_if.sv
// lfsr_checker_if
// Bundles the configuration, data-in and status signals of the LFSR pattern
// checker so the checker and its driver share one connection point.
//
//   cfg_we / cfg_tap : load feedback taps and restart acquisition
//   din_valid / din  : received word; din[0] is the leftmost literal bit
//   clr_cnt          : clear err_cnt and word_cnt
//   locked, err_pulse, err_cnt, word_cnt, state : checker status
//
// The master modport is the side that drives words in (bench, BIST
// controller); the slave modport is the checker itself.
interface lfsr_checker_if #(
    parameter int CNT_W = 16
);
    logic             cfg_we;
    logic [6:0]       cfg_tap;
    logic             din_valid;
    logic [0:7]       din;
    logic             clr_cnt;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] word_cnt;
    logic [1:0]       state;

    modport master (
        output cfg_we, cfg_tap, din_valid, din, clr_cnt,
        input  locked, err_pulse, err_cnt, word_cnt, state
    );

    modport slave (
        input  cfg_we, cfg_tap, din_valid, din, clr_cnt,
        output locked, err_pulse, err_cnt, word_cnt, state
    );
endinterface

// File: rtl/lfsr_checker.sv
// lfsr_checker
// Receive-side checker for the LFSR pattern generator. Seeds a local LFSR
// model from the incoming stream, confirms it over LOCK_CNT consecutive
// correct predictions, then free-runs (flywheels) and counts every word that
// disagrees with the prediction. UNLOCK_ERR consecutive misses drop lock.
//
// Ports:
//   clk    : clock, all state on rising edge
//   rst_n  : synchronous active-low reset
//   bus    : lfsr_checker_if.slave (cfg_we, cfg_tap, din_valid, din,
//            clr_cnt in; locked, err_pulse, err_cnt, word_cnt, state out)
// All outputs come straight from registers.
module lfsr_checker #(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_ERR = 3,
    parameter int CNT_W      = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    lfsr_checker_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEED   = 2'd1,
        ACQ    = 2'd2,
        LOCKED = 2'd3
    } state_e;

    localparam logic [3:0]       LOCK_N   = 4'(LOCK_CNT);
    localparam logic [3:0]       UNLOCK_N = 4'(UNLOCK_ERR);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q,     state_d;
    logic [6:0]       tap_q,       tap_d;
    logic [0:7]       exp_q,       exp_d;
    logic [3:0]       match_q,     match_d;
    logic [3:0]       miss_q,      miss_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_cnt_q,   err_cnt_d;
    logic [CNT_W-1:0] word_cnt_q,  word_cnt_d;

    // One generator step: bit 7 wraps to bit 0 and is folded into the tapped
    // positions on the way through.
    function automatic logic [0:7] lfsr_step(input logic [0:7] q, input logic [6:0] tap);
        logic [0:7] n;
        n[0] = q[7];
        for (int i = 1; i < 8; i++) begin
            n[i] = q[i-1] ^ (tap[7-i] & q[7]);
        end
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    always_comb begin
        // NOTE: every next-state value gets a default before any branch, so
        // no path leaves a signal unassigned and no latch is inferred.
        state_d     = state_q;
        tap_d       = tap_q;
        exp_d       = exp_q;
        match_d     = match_q;
        miss_d      = miss_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        word_cnt_d  = word_cnt_q;

        if (bus.cfg_we) begin
            // Reconfiguration wins over a coincident word, which is dropped.
            tap_d   = bus.cfg_tap;
            state_d = SEED;
            match_d = '0;
            miss_d  = '0;
        end else if (bus.din_valid) begin
            unique case (state_q)
                IDLE: ;
                SEED: begin
                    // All-zero is the LFSR lock-up state and cannot seed.
                    if (bus.din != 8'h00) begin
                        exp_d   = lfsr_step(bus.din, tap_q);
                        match_d = '0;
                        state_d = ACQ;
                    end
                end
                ACQ: begin
                    exp_d = lfsr_step(bus.din, tap_q);
                    if (bus.din == exp_q) begin
                        match_d = match_q + 4'd1;
                        if (match_d == LOCK_N) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        match_d = '0;
                        if (bus.din == 8'h00) state_d = SEED;
                    end
                end
                LOCKED: begin
                    // Flywheel: the prediction advances from itself, so a
                    // corrupted word never pollutes later predictions.
                    exp_d      = lfsr_step(exp_q, tap_q);
                    word_cnt_d = sat_inc(word_cnt_q);
                    if (bus.din == exp_q) begin
                        miss_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_cnt_d   = sat_inc(err_cnt_q);
                        miss_d      = miss_q + 4'd1;
                        if (miss_d == UNLOCK_N) begin
                            state_d = ACQ;
                            exp_d   = lfsr_step(bus.din, tap_q);
                            match_d = '0;
                        end
                    end
                end
            endcase
        end

        if (bus.clr_cnt) begin
            err_cnt_d  = '0;
            word_cnt_d = '0;
        end
    end

    // NOTE: reset is synchronous, so it is tested inside the clocked block
    // with clk as the only sensitivity; state updates use non-blocking
    // assignments so every register samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tap_q       <= '0;
            exp_q       <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            exp_q       <= exp_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign bus.locked    = (state_q == LOCKED);
    assign bus.state     = state_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.word_cnt  = word_cnt_q;
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker
// Drives two checkers (CNT_W=16 and CNT_W=4) with identical stimulus and
// compares both against a word-level reference model after every edge.
module tb_lfsr_checker;
    localparam int LOCK_CNT   = 4;
    localparam int UNLOCK_ERR = 3;
    localparam int MAX16      = 65535;
    localparam int MAX4       = 15;
    localparam logic [6:0] TAP_A = 7'b0100101;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lfsr_checker_if #(.CNT_W(16)) if16 ();
    lfsr_checker_if #(.CNT_W(4))  if4 ();

    lfsr_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_ERR(UNLOCK_ERR), .CNT_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(if16)
    );
    lfsr_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_ERR(UNLOCK_ERR), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(if4)
    );

    int n_checks = 0;
    int n_bad    = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h, want %0h", tag, cyc, got, want);
        end
    endtask

    // Word value with din[0] as bit 7: one generator step is a rotate right
    // by one, with the tap pattern xored in when the bit wrapping around is 1.
    function automatic logic [7:0] nxt(input logic [7:0] v, input logic [6:0] t);
        logic [7:0] r;
        r = {v[0], v[7:1]};
        return v[0] ? (r ^ {1'b0, t}) : r;
    endfunction

    // Reference model: mode 0=IDLE 1=SEED 2=ACQ 3=LOCKED.
    int         m_mode, m_run, m_miss;
    logic [6:0] m_tap;
    logic [7:0] m_exp;
    bit         m_pulse;
    int         m_err16, m_word16, m_err4, m_word4;

    // Generator model producing the "correct" stream.
    logic [7:0] g_word;
    logic [6:0] g_tap;

    function automatic int sat(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    task automatic model_edge(input bit rst, input bit we, input logic [6:0] tap,
                              input bit vld, input logic [7:0] d, input bit clr);
        bit bad;
        if (!rst) begin
            m_mode = 0; m_run = 0; m_miss = 0; m_tap = '0; m_exp = '0; m_pulse = 0;
            m_err16 = 0; m_word16 = 0; m_err4 = 0; m_word4 = 0;
            return;
        end
        m_pulse = 0;
        if (we) begin
            m_tap = tap; m_mode = 1; m_run = 0; m_miss = 0;
        end else if (vld) begin
            case (m_mode)
                1: if (d != 8'h00) begin m_exp = nxt(d, m_tap); m_run = 0; m_mode = 2; end
                2: begin
                    if (d == m_exp) begin
                        m_run++;
                        if (m_run == LOCK_CNT) begin m_mode = 3; m_miss = 0; end
                    end else begin
                        m_run = 0;
                        if (d == 8'h00) m_mode = 1;
                    end
                    m_exp = nxt(d, m_tap);
                end
                3: begin
                    bad = (d != m_exp);
                    m_exp = nxt(m_exp, m_tap);
                    m_word16 = sat(m_word16, MAX16);
                    m_word4  = sat(m_word4, MAX4);
                    if (!bad) m_miss = 0;
                    else begin
                        m_pulse = 1;
                        m_err16 = sat(m_err16, MAX16);
                        m_err4  = sat(m_err4, MAX4);
                        m_miss++;
                        if (m_miss == UNLOCK_ERR) begin
                            m_mode = 2; m_exp = nxt(d, m_tap); m_run = 0;
                        end
                    end
                end
                default: ;
            endcase
        end
        if (clr) begin
            m_err16 = 0; m_word16 = 0; m_err4 = 0; m_word4 = 0;
        end
    endtask

    // One clock: drive on the falling edge, update the model at the rising
    // edge, compare 1 time unit later.
    task automatic apply(input bit rst, input bit we, input logic [6:0] tap,
                         input bit vld, input logic [7:0] d, input bit clr);
        @(negedge clk);
        rst_n = rst;
        if16.cfg_we = we; if16.cfg_tap = tap; if16.din_valid = vld; if16.din = d; if16.clr_cnt = clr;
        if4.cfg_we  = we; if4.cfg_tap  = tap; if4.din_valid  = vld; if4.din  = d; if4.clr_cnt  = clr;
        @(posedge clk);
        model_edge(rst, we, tap, vld, d, clr);
        cyc++;
        #1;
        check("state",     32'(if16.state),     32'(m_mode));
        check("locked",    32'(if16.locked),    32'(m_mode == 3));
        check("err_pulse", 32'(if16.err_pulse), 32'(m_pulse));
        check("err_cnt",   32'(if16.err_cnt),   32'(m_err16));
        check("word_cnt",  32'(if16.word_cnt),  32'(m_word16));
        check("state4",    32'(if4.state),      32'(m_mode));
        check("err_cnt4",  32'(if4.err_cnt),    32'(m_err4));
        check("word_cnt4", 32'(if4.word_cnt),   32'(m_word4));
    endtask

    task automatic send(input logic [7:0] d);
        apply(1'b1, 1'b0, 7'd0, 1'b1, d, 1'b0);
    endtask

    task automatic good();
        send(g_word);
        g_word = nxt(g_word, g_tap);
    endtask

    // Send the generator's word with a corruption, keeping the generator running.
    task automatic corrupt(input logic [7:0] flip, input bit clr);
        apply(1'b1, 1'b0, 7'd0, 1'b1, g_word ^ flip, clr);
        g_word = nxt(g_word, g_tap);
    endtask

    task automatic idle(input bit clr);
        apply(1'b1, 1'b0, 7'd0, 1'b0, 8'h00, clr);
    endtask

    task automatic cfg(input logic [6:0] t, input logic [7:0] seed);
        apply(1'b1, 1'b1, t, 1'b0, 8'h00, 1'b0);
        g_tap = t; g_word = seed;
    endtask

    initial begin
        if16.cfg_we = 0; if16.cfg_tap = '0; if16.din_valid = 0; if16.din = '0; if16.clr_cnt = 0;
        if4.cfg_we  = 0; if4.cfg_tap  = '0; if4.din_valid  = 0; if4.din  = '0; if4.clr_cnt  = 0;
        g_tap = TAP_A; g_word = 8'hFF;

        // Reset state.
        apply(1'b0, 1'b0, 7'd0, 1'b0, 8'h00, 1'b0);
        apply(1'b0, 1'b1, 7'h7F, 1'b1, 8'hAA, 1'b1);
        check("rst_state", 32'(if16.state), 32'd0);

        // IDLE ignores words.
        send(8'hFF);
        check("idle_ignores", 32'(if16.state), 32'd0);

        // Clean lock: FF, DA, 6D, 93, ...
        cfg(TAP_A, 8'hFF);
        check("cfg_seed", 32'(if16.state), 32'd1);
        good();
        check("ff_seeds", 32'(if16.state), 32'd2);
        for (int i = 0; i < 3; i++) good();
        check("not_locked_4", 32'(if16.locked), 32'd0);
        good();
        check("locked_5", 32'(if16.locked), 32'd1);
        for (int i = 0; i < 6; i++) good();
        check("word_cnt_6", 32'(if16.word_cnt), 32'd6);

        // Single bit error while locked.
        corrupt(8'h04, 1'b0);
        check("bit_err_pulse", 32'(if16.err_pulse), 32'd1);
        check("bit_err_cnt", 32'(if16.err_cnt), 32'd1);
        check("bit_err_locked", 32'(if16.locked), 32'd1);
        good();
        check("flywheel_ok", 32'(if16.err_pulse), 32'd0);

        // Loss of lock after three consecutive misses, then relock.
        idle(1'b1);
        for (int i = 0; i < 3; i++) corrupt(8'h01, 1'b0);
        check("unlock_err", 32'(if16.err_cnt), 32'd3);
        check("unlock_state", 32'(if16.state), 32'd2);
        for (int i = 0; i < 6; i++) good();
        check("relock", 32'(if16.locked), 32'd1);

        // Zero seed.
        cfg(TAP_A, 8'hFF);
        send(8'h00);
        check("zero_seed1", 32'(if16.state), 32'd1);
        send(8'h00);
        check("zero_seed2", 32'(if16.state), 32'd1);
        good();
        good();
        check("da_match", 32'(if16.state), 32'd2);
        for (int i = 0; i < 3; i++) good();
        check("zero_relock", 32'(if16.locked), 32'd1);

        // clr_cnt together with a mismatch.
        corrupt(8'h10, 1'b1);
        check("clr_vs_err", 32'(if16.err_cnt), 32'd0);
        check("clr_vs_pulse", 32'(if16.err_pulse), 32'd1);

        // Gaps between words change nothing.
        idle(1'b0); idle(1'b0);
        good();

        // cfg_we with a coincident word: word dropped, lands in SEED.
        apply(1'b1, 1'b1, TAP_A, 1'b1, g_word, 1'b0);
        check("cfg_drop", 32'(if16.state), 32'd1);
        g_word = 8'hFF;
        for (int i = 0; i < 5; i++) good();
        check("pre_rst_lock", 32'(if16.locked), 32'd1);
        apply(1'b0, 1'b0, 7'd0, 1'b1, g_word, 1'b0);
        check("rst_locked", 32'(if16.locked), 32'd0);
        check("rst_words", 32'(if16.word_cnt), 32'd0);

        // Saturation of the 4-bit counters over repeated relock cycles.
        cfg(TAP_A, 8'hFF);
        for (int k = 0; k < 7; k++) begin
            for (int i = 0; i < 6; i++) good();
            for (int i = 0; i < 3; i++) corrupt(8'h80, 1'b0);
        end
        check("sat_err4", 32'(if4.err_cnt), 32'hF);
        check("sat_err16", 32'(if16.err_cnt), 32'd21);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (r < 2) begin
                apply(1'b0, 1'b0, 7'd0, 1'b0, 8'h00, 1'b0);
            end else if (r < 12) begin
                logic [6:0] t;
                logic [7:0] s;
                t = 7'($urandom);
                s = 8'($urandom_range(1, 255));
                apply(1'b1, 1'b1, t, $urandom_range(0, 1) == 1, 8'($urandom), 1'b0);
                g_tap = t; g_word = s;
            end else if (r < 200) begin
                apply(1'b1, 1'b0, 7'd0, 1'b0, 8'($urandom), $urandom_range(0, 49) == 0);
            end else if (r < 240) begin
                corrupt(8'(1 << $urandom_range(0, 7)), $urandom_range(0, 19) == 0);
            end else if (r < 255) begin
                apply(1'b1, 1'b0, 7'd0, 1'b1, 8'($urandom), 1'b0);
            end else if (r < 262) begin
                send(8'h00);
            end else begin
                apply(1'b1, 1'b0, 7'd0, 1'b1, g_word, $urandom_range(0, 49) == 0);
                g_word = nxt(g_word, g_tap);
            end
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
